// File: rtl/xge_crc_ctrl_pkg.sv
// Shared XGMII control codes, lane helpers and sequencer types
// for the xge_crc_ctrl timestamp-insertion front end.
package xge_crc_ctrl_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    localparam int LANES  = 8;
    localparam int BCNT_W = 14;
    localparam logic [BCNT_W-1:0] BCNT_MAX = 14'h3FFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0]  c;
        logic [63:0] d;
    } xgmii_t;

    // Byte of lane n; lane0 sits in the low byte.
    function automatic logic [7:0] lane_byte(input logic [63:0] d,
                                             input int n);
        return d[n*8 +: 8];
    endfunction

endpackage

// File: rtl/xgmii_lane_scan.sv
// Combinational XGMII word scanner: finds START / TERMINATE lanes
// and flags any ERROR control character.
module xgmii_lane_scan
    import xge_crc_ctrl_pkg::*;
(
    input  logic [63:0] xd_i,
    input  logic [7:0]  xc_i,
    output logic        start_hit_o,
    output logic [2:0]  start_lane_o,
    output logic        term_hit_o,
    output logic [2:0]  term_lane_o,
    output logic        ctl_err_o
);

    // Scan high to low so the lowest matching lane wins.
    always_comb begin
        start_hit_o  = 1'b0;
        start_lane_o = '0;
        term_hit_o   = 1'b0;
        term_lane_o  = '0;
        ctl_err_o    = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (xc_i[i] && lane_byte(xd_i, i) == XGMII_START) begin
                start_hit_o  = 1'b1;
                start_lane_o = 3'(i);
            end
            if (xc_i[i] && lane_byte(xd_i, i) == XGMII_TERM) begin
                term_hit_o  = 1'b1;
                term_lane_o = 3'(i);
            end
            if (xc_i[i] && lane_byte(xd_i, i) == XGMII_ERROR) begin
                ctl_err_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xge_crc_ctrl.sv
// Sequencer ahead of xge_crc: 3-sample look-ahead pipeline, frame
// tracking FSM, FCS-replace decision and saturating frame statistics.
module xge_crc_ctrl
    import xge_crc_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int MIN_LEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en_i,
    input  logic [63:0]      xd_i,
    input  logic [7:0]       xc_i,
    input  logic             mod_req_i,
    input  logic             rpl_en_i,
    input  logic             force_rpl_i,
    output logic [63:0]      xd_p3_o,
    output logic [7:0]       xc_p3_o,
    output logic [63:0]      xd_o,
    output logic [7:0]       xc_o,
    output logic             rpl_flag_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] rpl_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [BCNT_W:0] MIN_LEN_L = (BCNT_W + 1)'(MIN_LEN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        return (inc && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    logic       start_hit;
    logic [2:0] start_lane;
    logic       term_hit;
    logic [2:0] term_lane;
    logic       ctl_err;

    xgmii_lane_scan u_scan (
        .xd_i        (xd_i),
        .xc_i        (xc_i),
        .start_hit_o (start_hit),
        .start_lane_o(start_lane),
        .term_hit_o  (term_hit),
        .term_lane_o (term_lane),
        .ctl_err_o   (ctl_err)
    );

    xgmii_t            p3_q, p3_d;
    xgmii_t            s1_q, s1_d;
    xgmii_t            s2_q, s2_d;
    xgmii_t            out_q, out_d;
    state_e            state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              mod_q, mod_d;
    logic              bad_q, bad_d;
    logic              rpl_q, rpl_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  rpl_cnt_q, rpl_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [BCNT_W:0]   frame_len;
    logic              too_short;
    logic              bad_now;
    logic              elig;
    logic              close_ok;
    logic              open_new;
    logic              frame_inc;
    logic              rpl_inc;
    logic              err_inc;

    // Next-state: pipeline shift, frame FSM, replace decision, counters.
    always_comb begin
        p3_d        = p3_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        out_d       = out_q;
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        mod_d       = mod_q;
        bad_d       = bad_q;
        rpl_d       = rpl_q;
        open_new    = 1'b0;
        frame_inc   = 1'b0;
        rpl_inc     = 1'b0;
        err_inc     = 1'b0;

        frame_len = {1'b0, bcnt_q} + (BCNT_W + 1)'(term_lane);
        too_short = frame_len < MIN_LEN_L;
        bad_now   = bad_q | ctl_err;
        elig      = !bad_now && !too_short && rpl_en_i &&
                    (mod_q || force_rpl_i || mod_req_i);
        close_ok  = term_hit && (!start_hit || term_lane < start_lane);

        if (!clk_en_i) begin
            // A modify pulse between enabled samples must not be lost.
            if (state_q == ST_DATA && mod_req_i) begin
                mod_d = 1'b1;
            end
        end else begin
            p3_d  = '{c: xc_i, d: xd_i};
            s1_d  = p3_q;
            s2_d  = s1_q;
            out_d = s2_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (close_ok) begin
                        err_inc = 1'b1;
                    end
                    if (start_hit) begin
                        open_new = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (close_ok) begin
                        frame_inc = 1'b1;
                        rpl_inc   = elig;
                        err_inc   = bad_now | too_short;
                        rpl_d     = elig;
                        state_d   = ST_IDLE;
                        open_new  = start_hit;
                    end else if (start_hit) begin
                        err_inc  = 1'b1;
                        rpl_d    = 1'b0;
                        open_new = 1'b1;
                    end else begin
                        if (bcnt_q > BCNT_MAX - 14'd8) begin
                            bcnt_d = BCNT_MAX;
                        end else begin
                            bcnt_d = bcnt_q + 14'd8;
                        end
                        if (mod_req_i) begin
                            mod_d = 1'b1;
                        end
                        if (ctl_err) begin
                            bad_d = 1'b1;
                        end
                    end
                end
            endcase
            if (open_new) begin
                state_d = ST_DATA;
                bcnt_d  = 14'd8 - BCNT_W'(start_lane);
                mod_d   = 1'b0;
                bad_d   = 1'b0;
            end
        end

        frame_cnt_d = sat_inc(frame_cnt_q, frame_inc);
        rpl_cnt_d   = sat_inc(rpl_cnt_q, rpl_inc);
        err_cnt_d   = sat_inc(err_cnt_q, err_inc);
    end

    // State registers; reset drops all in-flight data immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p3_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            out_q       <= '0;
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            mod_q       <= 1'b0;
            bad_q       <= 1'b0;
            rpl_q       <= 1'b0;
            frame_cnt_q <= '0;
            rpl_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            p3_q        <= p3_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_q       <= out_d;
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            mod_q       <= mod_d;
            bad_q       <= bad_d;
            rpl_q       <= rpl_d;
            frame_cnt_q <= frame_cnt_d;
            rpl_cnt_q   <= rpl_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign xd_p3_o     = p3_q.d;
    assign xc_p3_o     = p3_q.c;
    assign xd_o        = out_q.d;
    assign xc_o        = out_q.c;
    assign rpl_flag_o  = rpl_q;
    assign frame_cnt_o = frame_cnt_q;
    assign rpl_cnt_o   = rpl_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_xge_crc_ctrl.sv
// Directed bench for xge_crc_ctrl: table of frame vectors plus
// hand sequences for reduced-rate enable and mid-frame reset.
module tb_xge_crc_ctrl;

    localparam int CNT_W = 16;
    localparam logic [7:0] C_S = 8'hFB;
    localparam logic [7:0] C_T = 8'hFD;
    localparam logic [7:0] C_I = 8'h07;

    localparam int K_IDLE  = 0;
    localparam int K_START = 1;
    localparam int K_TERM  = 2;
    localparam int K_DATA  = 3;
    localparam int K_COMBO = 4;

    typedef struct {
        bit   rst;
        int   kind;
        int   lane;
        logic mr;
        logic frc;
        logic en;
        logic exp_rpl;
        int   exp_frm;
        int   exp_rc;
        int   exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_en_i = 1'b1;
    logic [63:0]      xd_i = '0;
    logic [7:0]       xc_i = '0;
    logic             mod_req_i = 1'b0;
    logic             rpl_en_i = 1'b1;
    logic             force_rpl_i = 1'b0;
    logic [63:0]      xd_p3_o;
    logic [7:0]       xc_p3_o;
    logic [63:0]      xd_o;
    logic [7:0]       xc_o;
    logic             rpl_flag_o;
    logic [CNT_W-1:0] frame_cnt_o;
    logic [CNT_W-1:0] rpl_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [71:0] hist[$];
    vec_t tbl[$];

    xge_crc_ctrl #(.CNT_W(CNT_W), .MIN_LEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en_i   (clk_en_i),
        .xd_i       (xd_i),
        .xc_i       (xc_i),
        .mod_req_i  (mod_req_i),
        .rpl_en_i   (rpl_en_i),
        .force_rpl_i(force_rpl_i),
        .xd_p3_o    (xd_p3_o),
        .xc_p3_o    (xc_p3_o),
        .xd_o       (xd_o),
        .xc_o       (xc_o),
        .rpl_flag_o (rpl_flag_o),
        .frame_cnt_o(frame_cnt_o),
        .rpl_cnt_o  (rpl_cnt_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] mk(input int kind, input int lane,
                                       input int seed);
        logic [63:0] d;
        logic [7:0]  c;
        logic [7:0]  b;
        logic        f;
        for (int i = 0; i < 8; i++) begin
            b = 8'(8'h30 + seed * 8 + i);
            f = 1'b0;
            case (kind)
                K_IDLE: begin b = C_I; f = 1'b1; end
                K_START: begin
                    if (i < lane) begin b = C_I; f = 1'b1; end
                    else if (i == lane) begin b = C_S; f = 1'b1; end
                end
                K_TERM: begin
                    if (i == lane) begin b = C_T; f = 1'b1; end
                    else if (i > lane) begin b = C_I; f = 1'b1; end
                end
                K_COMBO: begin
                    if (i == 2) begin b = C_T; f = 1'b1; end
                    else if (i == 3) begin b = C_I; f = 1'b1; end
                    else if (i == 4) begin b = C_S; f = 1'b1; end
                end
                default: ;
            endcase
            d[i*8 +: 8] = b;
            c[i] = f;
        end
        return {c, d};
    endfunction

    task automatic step(input logic [71:0] w, input logic mr,
                        input logic en);
        xc_i      = w[71:64];
        xd_i      = w[63:0];
        mod_req_i = mr;
        clk_en_i  = en;
        @(posedge clk);
        #1;
        if (en) hist.push_back(w);
        mod_req_i = 1'b0;
        clk_en_i  = 1'b1;
    endtask

    task automatic chk_pipe(input string tag);
        chk({tag, " p3"}, {xc_p3_o, xd_p3_o}, hist[hist.size() - 1]);
        chk({tag, " out"}, {xc_o, xd_o}, hist[hist.size() - 4]);
    endtask

    task automatic chk_stats(input string tag, input logic rpl,
                             input int frm, input int rc, input int err);
        chk({tag, " rpl_flag"}, 72'(rpl_flag_o), 72'(rpl));
        chk({tag, " frame_cnt"}, 72'(frame_cnt_o), 72'(frm));
        chk({tag, " rpl_cnt"}, 72'(rpl_cnt_o), 72'(rc));
        chk({tag, " err_cnt"}, 72'(err_cnt_o), 72'(err));
    endtask

    task automatic do_reset(input string tag);
        logic [71:0] iw;
        iw = mk(K_IDLE, 0, 0);
        rst_n = 1'b0;
        xc_i = iw[71:64];
        xd_i = iw[63:0];
        mod_req_i = 1'b0;
        #2;
        chk({tag, " rst p3"}, {xc_p3_o, xd_p3_o}, 72'h0);
        chk({tag, " rst out"}, {xc_o, xd_o}, 72'h0);
        chk_stats({tag, " rst"}, 1'b0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(72'h0);
    endtask

    task automatic add(input bit rst, input int kind, input int lane,
                       input logic mr, input logic frc, input logic en,
                       input logic rpl, input int frm, input int rc,
                       input int err);
        vec_t v;
        v.rst = rst; v.kind = kind; v.lane = lane; v.mr = mr;
        v.frc = frc; v.en = en; v.exp_rpl = rpl; v.exp_frm = frm;
        v.exp_rc = rc; v.exp_err = err;
        tbl.push_back(v);
    endtask

    task automatic add_data(input int n, input logic frc, input logic rpl,
                            input int frm, input int rc, input int err);
        for (int i = 0; i < n; i++)
            add(0, K_DATA, 0, 1'b0, frc, 1'b1, rpl, frm, rc, err);
    endtask

    task automatic send_frame(input string tag, input int nd,
                              input int mod_at, input int seed);
        step(mk(K_START, 0, seed), 1'b0, 1'b1);
        chk_pipe(tag);
        for (int j = 0; j < nd; j++) begin
            step(mk(K_DATA, 0, seed + j + 1), (j == mod_at), 1'b1);
            chk_pipe(tag);
        end
        step(mk(K_TERM, 0, seed), 1'b0, 1'b1);
        chk_pipe(tag);
    endtask

    initial begin
        logic [71:0] w;

        // A: 64B frame with mod_req -> replace
        add(1, K_IDLE, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add_data(2, 0, 0, 0, 0, 0);
        add(0, K_DATA, 0, 1, 0, 1, 0, 0, 0, 0);
        add_data(4, 0, 0, 0, 0, 0);
        add(0, K_TERM, 0, 0, 0, 1, 1, 1, 1, 0);
        add(0, K_IDLE, 0, 0, 0, 1, 1, 1, 1, 0);
        // B: same frame, no mod, then force_rpl
        add(1, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add_data(7, 0, 0, 0, 0, 0);
        add(0, K_TERM, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, K_START, 0, 0, 1, 1, 0, 1, 0, 0);
        add_data(7, 1, 0, 1, 0, 0);
        add(0, K_TERM, 0, 0, 1, 1, 1, 2, 1, 0);
        // C: 60B frame with mod -> too short
        add(1, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, K_DATA, 0, 1, 0, 1, 0, 0, 0, 0);
        add_data(5, 0, 0, 0, 0, 0);
        add(0, K_TERM, 4, 0, 0, 1, 0, 1, 0, 1);
        // D: restart abort, then 72B frame with mod
        add(1, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add_data(3, 0, 0, 0, 0, 0);
        add(0, K_START, 0, 0, 0, 1, 0, 0, 0, 1);
        add_data(3, 0, 0, 0, 0, 1);
        add(0, K_DATA, 0, 1, 0, 1, 0, 0, 0, 1);
        add_data(4, 0, 0, 0, 0, 1);
        add(0, K_TERM, 0, 0, 0, 1, 1, 1, 1, 1);
        // E: TERM lane2 + START lane4 in one word
        add(1, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add_data(7, 0, 0, 0, 0, 0);
        add(0, K_COMBO, 0, 0, 0, 1, 0, 1, 0, 0);
        add_data(3, 0, 0, 1, 0, 0);
        add(0, K_DATA, 0, 1, 0, 1, 0, 1, 0, 0);
        add_data(4, 0, 0, 1, 0, 0);
        add(0, K_TERM, 0, 0, 0, 1, 1, 2, 1, 0);
        // F: replacement disabled; stray TERM in IDLE
        add(1, K_START, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_DATA, 0, 1, 0, 0, 0, 0, 0, 0);
        add_data(6, 0, 0, 0, 0, 0);
        add(0, K_TERM, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, K_TERM, 3, 0, 0, 1, 0, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            string tag;
            v = tbl[i];
            tag = $sformatf("v%0d", i);
            if (v.rst) do_reset(tag);
            rpl_en_i    = v.en;
            force_rpl_i = v.frc;
            step(mk(v.kind, v.lane, i), v.mr, 1'b1);
            chk_pipe(tag);
            chk_stats(tag, v.exp_rpl, v.exp_frm, v.exp_rc, v.exp_err);
        end

        // G: MII-rate enable, mod pulse during a disabled cycle
        rpl_en_i = 1'b1;
        force_rpl_i = 1'b0;
        do_reset("mii");
        for (int k = 0; k < 9; k++) begin
            if (k == 0) w = mk(K_START, 0, 40);
            else if (k == 8) w = mk(K_TERM, 0, 40);
            else w = mk(K_DATA, 0, 40 + k);
            for (int c = 0; c < 10; c++) begin
                step(w, (k == 3 && c == 4), (c == 9));
                chk_pipe($sformatf("mii k%0d c%0d", k, c));
            end
            if (k < 8) chk_stats($sformatf("mii k%0d", k), 1'b0, 0, 0, 0);
        end
        chk_stats("mii end", 1'b1, 1, 1, 0);
        for (int c = 0; c < 5; c++) begin
            step(mk(K_IDLE, 0, 0), 1'b0, 1'b0);
            chk_pipe("mii hold");
        end
        chk_stats("mii hold", 1'b1, 1, 1, 0);

        // H: async reset mid-frame, then a clean frame
        do_reset("mr");
        send_frame("mr f1", 7, 2, 60);
        chk_stats("mr f1", 1'b1, 1, 1, 0);
        step(mk(K_START, 0, 70), 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(mk(K_DATA, 0, 71 + j), 1'b1, 1'b1);
        do_reset("mr mid");
        for (int j = 0; j < 3; j++) begin
            step(mk(K_IDLE, 0, 0), 1'b0, 1'b1);
            chk_pipe("mr flush");
        end
        send_frame("mr f2", 7, 5, 80);
        chk_stats("mr f2", 1'b1, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
